// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] DEFAULT_HALT_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order FIFO holding fetched {instr, pc} pairs; flush empties it.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: one-deep memory pipeline feeding a 2-entry buffer.
// Optional feature macro: FETCH_PERF_CNT_EN adds a saturating fetch_count output.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'd0,
    parameter logic [WORD_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0] fetch_count
`endif
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              halted_q, halted_d;

    logic              redirect_act;
    logic              resp;
    logic              halt_resp;
    logic              push;
    logic              pop;
    logic              issue;
    logic [2:0]        occupancy;
    logic [1:0]        buf_count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // A response arriving in the redirect cycle belongs to the old path and is dropped.
    always_comb begin
        redirect_act = redirect_valid && (state_q != ST_IDLE);
        resp         = inflight_q && !redirect_act;
        halt_resp    = resp && (imem_data == HALT_WORD);
        push         = resp && !halt_resp;
        pop          = instr_valid && instr_ready;
        occupancy    = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
        issue        = (state_q == ST_RUN) && !redirect_act && !halt_resp
                       && (occupancy < 3'd2);
        push_entry   = '{instr: imem_data, pc: inflight_pc_q};
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        if (redirect_act) begin
            pc_d = redirect_target;
        end else if (issue) begin
            pc_d = pc_q + 32'd1;
        end
        case (state_q)
            ST_IDLE: if (start)        state_d = ST_RUN;
            ST_RUN:  if (redirect_act) state_d = ST_RUN;
                     else if (halt_resp) state_d = ST_HALT;
            ST_HALT: if (redirect_act) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            halted_q      <= halted_d;
        end
    end

    fetch_skid_buffer u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_act),
        .push_entry (push_entry),
        .head       (head),
        .count      (buf_count)
    );

    assign imem_addr   = pc_q;
    assign instr_valid = (buf_count != 2'd0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [WORD_W-1:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (pop && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, meaning the word index fetched first after start.
REQ-002 SHALL have parameter HALT_WORD, default 32'hDEADBEEF, meaning the instruction-memory out-of-bounds word that stops fetch.
REQ-003 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse, IDLE->RUN.
REQ-006 SHALL have port imem_addr  output  32  word index presented to instruction memory.
REQ-007 SHALL have port imem_data  input  32  instruction memory read data, valid one cycle after address sampled.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_target  input  32  word index of redirect destination.
REQ-010 SHALL have port instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-011 SHALL have port instr_ready  input  1  decode accepts this cycle.
REQ-012 SHALL have port instr  output  32  fetched instruction.
REQ-013 SHALL have port instr_pc  output  32  word index of instr.
REQ-014 SHALL have port halted  output  1  high while in HALT.

Function
REQ-015 SHALL implement states IDLE, RUN, HALT; IDLE->RUN on start; RUN->HALT on HALT_WORD response; HALT->RUN on redirect_valid; start ignored outside IDLE.
REQ-016 SHALL drive imem_addr combinationally from the internal pc register; an issue at edge k captures imem_data at edge k+1 (one in-flight slot, inflight flag).
REQ-017 SHALL issue (pc<=pc+1, inflight<=1) in RUN when no redirect and buffer count + inflight - pop < 2.
REQ-018 SHALL hold a 2-entry in-order buffer of {instr, pc}; head drives instr/instr_pc; instr_valid = count != 0.
REQ-019 SHALL pop the head when instr_valid && instr_ready; simultaneous push and pop keep count unchanged.
REQ-020 SHALL on redirect_valid (RUN or HALT) flush the buffer, discard any in-flight response, set pc<=redirect_target, issue nothing that cycle, issue target next cycle.
REQ-021 SHALL ignore redirect_valid in IDLE.
REQ-022 SHALL not push a response equal to HALT_WORD; state->HALT, no further issues, already-buffered entries still drain.
REQ-023 SHALL wrap pc from 32'hFFFFFFFF to 0 without error.
REQ-024 SHALL sustain one instruction per cycle with instr_ready held high, first instr_valid two cycles after start.

Reset
REQ-025 SHALL on rst_n low at a clock edge set state=IDLE, pc=RESET_PC, inflight=0, count=0, halted=0, instr_valid=0, instr=0, instr_pc=0, regardless of state or in-flight request.
REQ-026 SHALL treat reset as dominant over start and redirect_valid in the same cycle.

Configuration
REQ-027 SHALL, with FETCH_PERF_CNT_EN defined, add output fetch_count (32 bits) incremented on each pop, cleared by reset, saturating at 32'hFFFFFFFF.
REQ-028 SHALL, without FETCH_PERF_CNT_EN, have no fetch_count port or counter logic.

Structure
REQ-029 SHALL place the state enum, word-width constant and default HALT_WORD in shared package fetch_pkg.
REQ-030 SHALL implement the buffer as sub-module fetch_skid_buffer (2-entry FIFO, push/pop/flush, count).

Verification
REQ-031 Reset, start, instr_ready=1, memory 0..4 -> instr_pc 0,1,2,3,4 on consecutive cycles, first valid 2 cycles after start.
REQ-032 instr_ready=0 for 5 cycles after first valid -> count reaches 2, imem_addr frozen at 2, no loss; release -> pcs 0,1,2 in order.
REQ-033 redirect_valid with target 14 while pc 9 in flight -> pc 9 response dropped, next valid instr_pc=14.
REQ-034 memory word 20 = 32'hDEADBEEF -> instr_pc 19 delivered, halted=1, no issue after; redirect target 0 -> halted=0, instr_pc 0 next.
REQ-035 rst_n low with buffer full and in-flight -> next cycle instr_valid=0, imem_addr=RESET_PC, state IDLE.
REQ-036 FETCH_PERF_CNT_EN defined, 10 pops -> fetch_count=10; reset -> 0.
